lan_bus_master: RTL and testbench

//  Parametrised host-bus transaction engine for the external Ethernet controller (CS/RD/WR, 16-bit parallel bus).

---
 rtl/lan_bus_master.sv | 168 ++++++++++++++++
 tb/tb_lan_bus_master.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lan_bus_master.sv
// Host-bus transaction engine for an external Ethernet controller: power-up reset
// sequencing on LanRst, then single/burst CS/RD/WR register accesses with programmable timing.
module lan_bus_master #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int ADDR_STEP  = 2,
  parameter int LEN_W      = 8,
  parameter int SETUP_CYC  = 5,
  parameter int STROBE_CYC = 5,
  parameter int HOLD_CYC   = 5,
  parameter int RST_PRE    = 1000000,
  parameter int RST_LOW    = 500,
  parameter int RST_WAIT   = 1000000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWdata,
  input  logic [LEN_W-1:0]  ReqLen,
  output logic              RspValid,
  output logic              RspLast,
  output logic [DATA_W-1:0] RspRdata,
  input  logic              ResetReq,
  output logic              InitDone,
  output logic              IrqSync,
  output logic [ADDR_W-1:0] LanAddr,
  inout  wire  [DATA_W-1:0] LanData,
  output logic              LanCs,
  output logic              LanRd,
  output logic              LanWr,
  output logic              LanRst,
  input  logic              LanIrq
);

  localparam int MAX_CYC = (RST_PRE > RST_WAIT) ? RST_PRE : RST_WAIT;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    R_PRE, R_LOW, R_WAIT, IDLE, SETUP, STROBE, HOLD
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               beat_done;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               data_oe;
  logic               cs_q, rd_q, wr_pin_q, rst_pin_q;
  logic               rsp_valid_q, rsp_last_q;
  logic               irq_meta, irq_sync;

  function automatic logic at_end(input logic [CNT_W-1:0] c, input int n);
    return c == CNT_W'(n - 1);
  endfunction

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise any path that skips an assignment infers a latch.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    beat_done = 1'b0;
    case (state)
      R_PRE:  if (at_end(cnt, RST_PRE))  state_n = R_LOW;
      R_LOW:  if (at_end(cnt, RST_LOW))  state_n = R_WAIT;
      R_WAIT: if (at_end(cnt, RST_WAIT)) state_n = IDLE;
      IDLE: begin
        if (ResetReq) begin
          state_n = R_PRE;
        end else if (ReqValid) begin
          state_n = SETUP;
          accept  = 1'b1;
        end
      end
      SETUP:  if (at_end(cnt, SETUP_CYC))  state_n = STROBE;
      STROBE: if (at_end(cnt, STROBE_CYC)) state_n = HOLD;
      HOLD: begin
        if (at_end(cnt, HOLD_CYC)) begin
          beat_done = 1'b1;
          state_n   = (beat_q == len_q) ? IDLE : SETUP;
        end
      end
      default: state_n = R_PRE;
    endcase
  end

  // A pending reset request withholds ready so a request is never handshaken but dropped.
  assign ReqReady = (state == IDLE) && !ResetReq;
  assign InitDone = (state != R_PRE) && (state != R_LOW) && (state != R_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= R_PRE;
      cnt         <= '0;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_pin_q    <= 1'b1;
      rst_pin_q   <= 1'b1;
      data_oe     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + CNT_W'(1);

      // Pins are registered from the next state so CS and RD/WR move on the same edge, glitch-free.
      cs_q      <= (state_n != STROBE);
      rd_q      <= !((state_n == STROBE) && !wr_q);
      wr_pin_q  <= !((state_n == STROBE) && wr_q);
      rst_pin_q <= (state_n != R_LOW);
      data_oe   <= ((state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD))
                   && (accept ? ReqWrite : wr_q);

      if (accept) begin
        wr_q    <= ReqWrite;
        addr_q  <= ReqAddr;
        wdata_q <= ReqWdata;
        len_q   <= ReqLen;
        beat_q  <= '0;
      end else if (beat_done && (beat_q != len_q)) begin
        addr_q <= addr_q + ADDR_W'(ADDR_STEP);
        beat_q <= beat_q + LEN_W'(1);
      end

      if ((state == STROBE) && at_end(cnt, STROBE_CYC) && !wr_q) rdata_q <= LanData;

      rsp_valid_q <= beat_done;
      rsp_last_q  <= beat_done && (beat_q == len_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      irq_meta <= 1'b1;
      irq_sync <= 1'b1;
    end else begin
      irq_meta <= LanIrq;
      irq_sync <= irq_meta;
    end
  end

  assign LanData  = data_oe ? wdata_q : {DATA_W{1'bz}};
  assign LanAddr  = addr_q;
  assign LanCs    = cs_q;
  assign LanRd    = rd_q;
  assign LanWr    = wr_pin_q;
  assign LanRst   = rst_pin_q;
  assign RspValid = rsp_valid_q;
  assign RspLast  = rsp_last_q;
  assign RspRdata = rdata_q;
  assign IrqSync  = irq_sync;

endmodule

// File: tb/tb_lan_bus_master.sv
// Bench for lan_bus_master: directed requests, per-cycle pin checks, and a response
// scoreboard drained by an independent monitor.
module tb_lan_bus_master;

  logic        Clk = 1'b0;
  logic        Rst, ReqValid, ReqWrite, ResetReq, LanIrq;
  logic [9:0]  ReqAddr;
  logic [15:0] ReqWdata;
  logic [7:0]  ReqLen;
  logic        ReqReady, RspValid, RspLast, InitDone, IrqSync;
  logic [15:0] RspRdata;
  logic [9:0]  LanAddr;
  logic        LanCs, LanRd, LanWr, LanRst;
  wire  [15:0] LanData;
  logic [15:0] model_rdata;

  typedef struct packed {
    logic        last;
    logic [15:0] rdata;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [15:0] exp_rdata = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 Clk = ~Clk;

  // Controller model drives the bus only while it sees a read strobe.
  assign LanData = !LanRd ? model_rdata : 16'hzzzz;

  lan_bus_master #(
    .ADDR_W(10), .DATA_W(16), .ADDR_STEP(2), .LEN_W(8),
    .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2),
    .RST_PRE(4), .RST_LOW(2), .RST_WAIT(4)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWdata(ReqWdata), .ReqLen(ReqLen),
    .RspValid(RspValid), .RspLast(RspLast), .RspRdata(RspRdata),
    .ResetReq(ResetReq), .InitDone(InitDone), .IrqSync(IrqSync),
    .LanAddr(LanAddr), .LanData(LanData),
    .LanCs(LanCs), .LanRd(LanRd), .LanWr(LanWr), .LanRst(LanRst),
    .LanIrq(LanIrq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin : monitor
    rsp_t e;
    if (RspValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_queue_depth", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("rsp_last", RspLast, e.last);
        check("rsp_rdata", RspRdata, e.rdata);
      end
    end
  end

  // Issues one request and checks the pins cycle by cycle: 2 setup, 3 strobe, 2 hold per beat.
  task automatic run_req(input logic wr, input logic [9:0] addr, input logic [15:0] wd,
                         input logic [7:0] len, input logic [15:0] rmodel);
    logic [9:0] a;
    logic       strobe;
    int         n;
    model_rdata = rmodel;
    for (int b = 0; b <= int'(len); b++) begin
      if (!wr) exp_rdata = rmodel;
      exp_q.push_back('{last: (b == int'(len)), rdata: exp_rdata});
    end
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqWdata = wd; ReqLen = len;
    n = 0;
    while (!ReqReady && n < 64) begin
      @(negedge Clk);
      n++;
    end
    check("req_ready", ReqReady, 1);
    @(negedge Clk);
    ReqValid = 1'b0;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      for (int c = 0; c < 7; c++) begin
        if (!(b == 0 && c == 0)) @(negedge Clk);
        strobe = (c >= 2) && (c <= 4);
        check($sformatf("pins a%0h b%0d c%0d", addr, b, c),
              {LanCs, LanRd, LanWr, LanRst, LanAddr},
              {!strobe, !(strobe && !wr), !(strobe && wr), 1'b1, a});
        if (wr) check($sformatf("wdata b%0d c%0d", b, c), LanData, wd);
      end
      a = a + 10'd2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ResetReq = 1'b0; LanIrq = 1'b1;
    ReqAddr = '0; ReqWdata = '0; ReqLen = '0; model_rdata = '0;
    @(negedge Clk);
    Rst = 1'b0;

    check("reset_pins", {LanCs, LanRd, LanWr, LanAddr, RspValid, RspLast, IrqSync, ReqReady},
          {1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0});
    check("reset_rdata", RspRdata, 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("lan_rst cyc%0d", i), LanRst, (i < 4 || i >= 6) ? 1 : 0);
      check($sformatf("init_done_low cyc%0d", i), InitDone, 0);
      @(negedge Clk);
    end
    check("init_done_high", InitDone, 1);
    check("req_ready_idle", ReqReady, 1);

    LanIrq = 1'b0;
    @(negedge Clk);
    check("irq_sync_stage1", IrqSync, 1);
    @(negedge Clk);
    check("irq_sync_stage2", IrqSync, 0);
    LanIrq = 1'b1;

    run_req(1'b1, 10'h008, 16'hAABB, 8'd0, 16'h0000);
    run_req(1'b0, 10'h0FE, 16'h0000, 8'd0, 16'h5300);
    run_req(1'b1, 10'h3FE, 16'h1357, 8'd2, 16'h0000);

    // Abort a write with Rst while the strobe is low.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 10'h020; ReqWdata = 16'hCAFE; ReqLen = 8'd0;
    check("abort_ready", ReqReady, 1);
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("abort_in_strobe", {LanCs, LanWr}, 2'b00);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    exp_rdata = '0;
    check("abort_pins", {LanCs, LanRd, LanWr, LanRst, InitDone}, 5'b11110);
    n = 0;
    while (!InitDone && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("abort_reset_cycles", n, 10);

    // ResetReq wins over a simultaneous request; the request is taken after re-init.
    ResetReq = 1'b1; ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 10'h010; ReqLen = 8'd0;
    @(negedge Clk);
    ResetReq = 1'b0;
    check("resetreq_not_accepted", {ReqReady, InitDone, LanCs}, 3'b001);
    n = 0;
    while (!ReqReady && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("resetreq_reset_cycles", n, 10);
    run_req(1'b0, 10'h010, 16'h0000, 8'd0, 16'h1234);
    run_req(1'b1, 10'h100, 16'h0F0F, 8'd1, 16'h0000);

    repeat (3) @(negedge Clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
